// File: rtl/plot_pkg.sv
// Shared types and constants for the pixel-plot sink.
// Optional feature: PLOT_COLOUR_KEY_EN (transparent colour key).
package plot_pkg;

  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int COL_W      = 3;
  localparam int H_RES      = 160;
  localparam int V_RES      = 120;
  localparam int ADDR_W     = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  localparam logic [COL_W-1:0] KEY_COLOUR = 3'b101;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour;
  } fb_entry_t;

  typedef enum logic {
    IDLE,
    WRITE
  } out_state_t;

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [ADDR_W-1:0] xy_to_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 7) + (yy << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Plot stream and framebuffer write bus of the plot sink.
// master drives plots and acks; slave is the sink.
interface plot_sink_if;
  import plot_pkg::*;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [COL_W-1:0]  colour;
  logic              plot;
  logic              plot_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic [COL_W-1:0]  fb_data;
  logic              fb_we;
  logic              fb_ack;

  modport master (
    output x, y, colour, plot, fb_ack,
    input  plot_ready, fb_addr, fb_data, fb_we
  );

  modport slave (
    input  x, y, colour, plot, fb_ack,
    output plot_ready, fb_addr, fb_data, fb_we
  );

endinterface

// File: rtl/plot_fifo.sv
// Pending-plot FIFO: synchronous, full/empty/level flags.
// Optional feature: none.
module plot_fifo
  import plot_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  fb_entry_t        din,
  input  logic             pop,
  output fb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  fb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_q - rd_q;
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/plot_sink.sv
// Validates plots, queues them and issues framebuffer writes.
// Optional feature: PLOT_COLOUR_KEY_EN drops plots of KEY_COLOUR.
module plot_sink
  import plot_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  plot_sink_if.slave bus,
  output logic       busy,
  output logic [7:0] drop_count
);

  out_state_t       state_q;
  out_state_t       state_d;
  fb_entry_t        out_q;
  fb_entry_t        din;
  fb_entry_t        dout;
  logic             rdy_q;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             accept;
  logic             in_range;
  logic             keyed;
  logic             push;
  logic             drop;
  logic             pop;

  // keeps plot_ready low through reset and the reset edge itself
  always_ff @(posedge clk) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign bus.plot_ready = rdy_q & ~full;
  assign accept   = bus.plot & bus.plot_ready;
  assign in_range = (bus.x < X_W'(H_RES)) &&
                    (bus.y < Y_W'(V_RES));

`ifdef PLOT_COLOUR_KEY_EN
  assign keyed = (bus.colour == KEY_COLOUR);
`else
  assign keyed = 1'b0;
`endif

  assign push = accept & in_range & ~keyed;
  assign drop = accept & ~in_range;
  assign din  = '{addr: xy_to_addr(bus.x, bus.y),
                  colour: bus.colour};

  plot_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.fb_ack) begin
          if (!empty) pop     = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  out_q <= '0;
    else if (pop)  out_q <= dout;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      drop_count <= '0;
    else if (drop && drop_count != 8'hff)
      drop_count <= drop_count + 8'd1;
  end

  assign bus.fb_we   = (state_q == WRITE);
  assign bus.fb_addr = out_q.addr;
  assign bus.fb_data = out_q.colour;
  assign busy        = (level != '0) | bus.fb_we;

endmodule

// File: tb/tb_plot_sink.sv
// Scoreboard bench for plot_sink: directed cases plus random traffic.
// Honours PLOT_COLOUR_KEY_EN when defined.
module tb_plot_sink;
  import plot_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [7:0] drop_count;

  plot_sink_if bus();

  plot_sink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int col;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model_drop = 0;
  int   writes = 0;
  int   ix, iy, ic;

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plot(int xx, int yy, int cc, bit p);
    bus.x      = 8'(xx);
    bus.y      = 7'(yy);
    bus.colour = 3'(cc);
    bus.plot   = p;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy still %0d want 0", busy);
    end
  endtask

  // reference model: what each accepted plot should become
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      model_drop = 0;
    end else if (bus.plot && bus.plot_ready) begin
      ix = int'(bus.x);
      iy = int'(bus.y);
      ic = int'(bus.colour);
      if (ix >= 160 || iy >= 120) begin
        if (model_drop < 255) model_drop++;
      end else begin
`ifdef PLOT_COLOUR_KEY_EN
        if (ic != 5)
`endif
        sb.push_back('{iy * 160 + ix, ic});
      end
    end
  end

  logic stall_q = 1'b0;
  int   stall_addr, stall_data;
  exp_t e;

  // monitor: compare each accepted write against the scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_we", int'(bus.fb_we), 1);
        check("stall_addr", int'(bus.fb_addr), stall_addr);
        check("stall_data", int'(bus.fb_data), stall_data);
      end
      stall_q = 1'b0;
      if (bus.fb_we) begin
        if (bus.fb_ack) begin
          writes++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr %0d with 0 pending want none",
                     bus.fb_addr);
          end else begin
            e = sb.pop_front();
            check("wr_addr", int'(bus.fb_addr), e.addr);
            check("wr_data", int'(bus.fb_data), e.col);
          end
        end else begin
          stall_q    = 1'b1;
          stall_addr = int'(bus.fb_addr);
          stall_data = int'(bus.fb_data);
        end
      end
    end
  end

  int w0, n, last, nr;

  initial begin
    set_plot(0, 0, 0, 1'b0);
    bus.fb_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_we", int'(bus.fb_we), 0);
    check("rst_ready", int'(bus.plot_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_addr", int'(bus.fb_addr), 0);
    reset_n = 1'b1;
    tick();
    check("rel_ready", int'(bus.plot_ready), 1);

    // single plot latency
    bus.fb_ack = 1'b1;
    set_plot(5, 2, 6, 1'b1);
    tick();
    bus.plot = 1'b0;
    check("t1_we_n1", int'(bus.fb_we), 0);
    tick();
    check("t1_we_n2", int'(bus.fb_we), 1);
    check("t1_addr", int'(bus.fb_addr), 325);
    check("t1_data", int'(bus.fb_data), 6);
    tick();
    check("t1_we_n3", int'(bus.fb_we), 0);

    // range boundaries
    w0 = writes;
    set_plot(159, 119, 2, 1'b1);
    tick();
    set_plot(160, 0, 2, 1'b1);
    tick();
    set_plot(0, 120, 2, 1'b1);
    tick();
    bus.plot = 1'b0;
    wait_idle();
    tick();
    check("t2_writes", writes - w0, 1);
    check("t2_drop", int'(drop_count), 2);

    // fill under stall, then drain back-to-back
    bus.fb_ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_plot(i * 3, i, i, 1'b1);
      check("t3_ready", int'(bus.plot_ready), (i < 5) ? 1 : 0);
      tick();
    end
    bus.plot = 1'b0;
    check("t3_stalled_we", int'(bus.fb_we), 1);
    bus.fb_ack = 1'b1;
    n = 0;
    last = -1;
    for (int k = 0; k < 12; k++) begin
      if (bus.fb_we) begin
        n++;
        last = k;
      end
      tick();
    end
    check("t3_count", n, 5);
    check("t3_last", last, 4);

    // drop counter saturation
    w0 = writes;
    nr = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 2 == 0)
        set_plot(160 + int'($urandom % 96), int'($urandom % 128), 1, 1'b1);
      else
        set_plot(int'($urandom % 160), 120 + int'($urandom % 8), 1, 1'b1);
      if (!bus.plot_ready) nr++;
      tick();
    end
    bus.plot = 1'b0;
    tick();
    check("t4_not_ready", nr, 0);
    check("t4_drop", int'(drop_count), 255);
    check("t4_drop_model", int'(drop_count), model_drop);
    check("t4_writes", writes - w0, 0);

    // reset with writes pending
    bus.fb_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_plot(10 + i, 20, 3, 1'b1);
      tick();
    end
    bus.plot = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    check("t5_we", int'(bus.fb_we), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_drop", int'(drop_count), 0);
    check("t5_ready", int'(bus.plot_ready), 0);
    reset_n = 1'b1;
    bus.fb_ack = 1'b1;
    w0 = writes;
    repeat (10) tick();
    check("t5_writes", writes - w0, 0);
    check("t5_ready_rel", int'(bus.plot_ready), 1);

    // key colour
    w0 = writes;
    set_plot(10, 10, 5, 1'b1);
    tick();
    bus.plot = 1'b0;
    wait_idle();
    tick();
`ifdef PLOT_COLOUR_KEY_EN
    check("t6_writes", writes - w0, 0);
`else
    check("t6_writes", writes - w0, 1);
`endif
    check("t6_drop", int'(drop_count), 0);

    // random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      set_plot(int'($urandom % 176), int'($urandom % 128),
               int'($urandom % 8), ($urandom % 3) != 0);
      bus.fb_ack = $urandom % 2;
      tick();
    end
    bus.plot = 1'b0;
    bus.fb_ack = 1'b1;
    wait_idle();
    tick();
    check("rnd_pending", sb.size(), 0);
    check("rnd_drop", int'(drop_count), model_drop);
    check("rnd_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
